// File: rtl/rejection_sampler_ctrl.sv
// rejection_sampler_ctrl
//   Drives a combinational constraint checker with pseudo-random candidates.
//   A 64-bit xorshift PRNG builds each candidate one 64-bit chunk per cycle.
//   The checker's sat_i verdict is sampled for one cycle. Accepted candidates
//   are streamed out until n_req have been delivered. A run stops early with
//   fail_o when one sample is rejected MAX_TRIES times in a row.
//
// Ports
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   start_i       one-cycle run request, honoured only while idle
//   seed_i        PRNG seed, latched on an accepted start (0 -> golden constant)
//   n_req_i       number of samples to produce, latched on an accepted start
//   cand_o        registered candidate presented to the checker
//   sat_i         checker verdict for cand_o, sampled only in the check cycle
//   out_valid     accepted sample available on out_data
//   out_ready     consumer accepts the sample
//   out_data      accepted sample (the current candidate)
//   busy_o        run in progress
//   done_o        one-cycle pulse at the end of a run
//   fail_o        last run hit the try limit; held until the next accepted start
//   dbg_state_o   current FSM state, for observation only
//   stat_tries_o  (SAMPLER_STATS_EN only) check cycles since the last start
//
// Configuration
//   SAMPLER_STATS_EN  when defined, adds the saturating stat_tries_o counter.
//
// Output handshake: out_data is valid while out_valid is high. A sample
// transfers on a rising edge where out_valid && out_ready. Once raised,
// out_valid and out_data stay stable until that transfer. out_valid is a
// register and does not depend combinationally on out_ready.

module rejection_sampler_ctrl #(
    parameter int CAND_W    = 779,
    parameter int MAX_TRIES = 1024,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [63:0]       seed_i,
    input  logic [CNT_W-1:0]  n_req_i,
    output logic [CAND_W-1:0] cand_o,
    input  logic              sat_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CAND_W-1:0] out_data,
    output logic              busy_o,
    output logic              done_o,
    output logic              fail_o,
    output logic [2:0]        dbg_state_o
`ifdef SAMPLER_STATS_EN
    ,
    output logic [31:0]       stat_tries_o
`endif
);

    localparam int NCHUNK  = (CAND_W + 63) / 64;
    localparam int FILL_W  = NCHUNK * 64;
    localparam int CHUNK_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int TRY_W   = $clog2(MAX_TRIES + 1);

    localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(NCHUNK - 1);
    localparam logic [CHUNK_W-1:0] CHUNK_ONE  = CHUNK_W'(1);
    localparam logic [TRY_W-1:0]   TRY_LIMIT  = TRY_W'(MAX_TRIES);
    localparam logic [TRY_W-1:0]   TRY_ONE    = TRY_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [63:0]        GOLDEN     = 64'h9E3779B97F4A7C15;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_CHECK = 3'd2,
        S_EMIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state_q;
    logic [63:0]        prng_q;
    logic [63:0]        prng_d;
    logic [FILL_W-1:0]  fill_q;
    logic [FILL_W-1:0]  fill_d;
    logic [CAND_W-1:0]  cand_q;
    logic [CHUNK_W-1:0] chunk_q;
    logic [TRY_W-1:0]   tries_q;
    logic [CNT_W-1:0]   accepts_q;
    logic [CNT_W-1:0]   n_req_q;
    logic               out_valid_q;
    logic               busy_q;
    logic               done_q;
    logic               fail_q;
    logic [63:0]        seed_init;

    assign seed_init = (seed_i == 64'd0) ? GOLDEN : seed_i;

    // One xorshift64 step, and the fill buffer with that step written as the
    // current chunk. The candidate is built in fill_q so that cand_o keeps
    // the previous candidate until the whole fill is complete.
    always_comb begin
        prng_d = prng_q;
        prng_d = prng_d ^ (prng_d << 13);
        prng_d = prng_d ^ (prng_d >> 7);
        prng_d = prng_d ^ (prng_d << 17);
        fill_d = fill_q;
        fill_d[{chunk_q, 6'b000000} +: 64] = prng_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            prng_q      <= '0;
            fill_q      <= '0;
            cand_q      <= '0;
            chunk_q     <= '0;
            tries_q     <= '0;
            accepts_q   <= '0;
            n_req_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        prng_q    <= seed_init;
                        n_req_q   <= n_req_i;
                        accepts_q <= '0;
                        tries_q   <= '0;
                        chunk_q   <= '0;
                        fail_q    <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= (n_req_i == '0) ? S_DONE : S_FILL;
                    end
                end
                S_FILL: begin
                    prng_q <= prng_d;
                    fill_q <= fill_d;
                    if (chunk_q == LAST_CHUNK) begin
                        // Bits of the last chunk above CAND_W are dropped here.
                        cand_q  <= fill_d[CAND_W-1:0];
                        chunk_q <= '0;
                        state_q <= S_CHECK;
                    end else begin
                        chunk_q <= chunk_q + CHUNK_ONE;
                    end
                end
                S_CHECK: begin
                    if (sat_i) begin
                        tries_q     <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_EMIT;
                    end else if (tries_q + TRY_ONE == TRY_LIMIT) begin
                        tries_q <= '0;
                        fail_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        tries_q <= tries_q + TRY_ONE;
                        state_q <= S_FILL;
                    end
                end
                S_EMIT: begin
                    // PRNG and candidate are held here until the transfer.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        accepts_q   <= accepts_q + CNT_ONE;
                        state_q     <= (accepts_q + CNT_ONE == n_req_q) ? S_DONE : S_FILL;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef SAMPLER_STATS_EN
    logic [31:0] stat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q <= '0;
        end else if (state_q == S_IDLE && start_i) begin
            stat_q <= '0;
        end else if (state_q == S_CHECK && stat_q != 32'hFFFF_FFFF) begin
            stat_q <= stat_q + 32'd1;
        end
    end

    assign stat_tries_o = stat_q;
`endif

    assign cand_o      = cand_q;
    assign out_data    = cand_q;
    assign out_valid   = out_valid_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign fail_o      = fail_q;
    assign dbg_state_o = state_q;

endmodule
